// File: rtl/idct16_pair_if.sv
// idct16_pair_if: coefficient-pair input and mirrored sample-pair output bundle.
// The master side feeds coefficients; the slave side is the transform.
interface idct16_pair_if;
  logic              in_valid;
  logic signed [23:0] COEFF_A;
  logic signed [23:0] COEFF_B;
  logic [3:0]        INDEX_A;
  logic [3:0]        INDEX_B;
  logic              in_ready;
  logic [7:0]        OUTPUT_A;
  logic [7:0]        OUTPUT_B;
  logic              output_en;
  logic              overrun;

  modport master (
    output in_valid, COEFF_A, COEFF_B, INDEX_A, INDEX_B,
    input  in_ready, OUTPUT_A, OUTPUT_B, output_en, overrun
  );

  modport slave (
    input  in_valid, COEFF_A, COEFF_B, INDEX_A, INDEX_B,
    output in_ready, OUTPUT_A, OUTPUT_B, output_en, overrun
  );
endinterface

// File: rtl/idct16_pair.sv
// idct16_pair: 16-point inverse DCT, tagged coefficient pairs in, (n,15-n) samples out.
// Define IDCT_ROUND_EN for round-half-up before the final shift (default: floor).
module idct16_pair #(
  parameter int SCALE_SHIFT = 3,
  parameter int ACC_W       = 40
) (
  input logic          clk,
  input logic          reset,
  idct16_pair_if.slave bus
);
  localparam int SH = 16 + SCALE_SHIFT;

  typedef enum logic [1:0] {
    COLLECT, COMPUTE, FINAL, OUTPUT
  } state_e;

  state_e state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic signed [23:0] coef_q [16];
  logic signed [23:0] coef_d [16];
  logic [7:0] samp_q [16];
  logic [7:0] samp_d [16];
  logic signed [ACC_W-1:0] acc_a_q, acc_a_d;
  logic signed [ACC_W-1:0] acc_b_q, acc_b_d;
  logic [6:0] cnt_q, cnt_d;
  logic [3:0] oidx_q, oidx_d;
  logic in_ready_q, in_ready_d;
  logic out_en_q, out_en_d;
  logic overrun_q, overrun_d;
  logic [7:0] out_a_q, out_a_d;
  logic [7:0] out_b_q, out_b_d;

  logic [2:0] p;
  logic [3:0] k;
  logic signed [9:0] cos_c;
  logic signed [ACC_W-1:0] prod, sum_a, sum_b;

  // C[p][k] = round(256*cos((2p+1)k*pi/32)), folded onto a quarter-wave table
  function automatic logic signed [9:0] cos_rom(
    input logic [2:0] pp,
    input logic [3:0] kk
  );
    logic [5:0] m;
    logic [4:0] j;
    logic       neg;
    logic [8:0] t;
    m   = {2'b0, pp, 1'b1} * {2'b0, kk};
    neg = 1'b0;
    if (m <= 6'd16) begin
      j = m[4:0];
    end else if (m <= 6'd32) begin
      j = 5'(6'd32 - m);
      neg = 1'b1;
    end else if (m <= 6'd48) begin
      j = 5'(m - 6'd32);
      neg = 1'b1;
    end else begin
      j = 5'(7'd64 - {1'b0, m});
    end
    case (j)
      5'd0:  t = 9'd256;
      5'd1:  t = 9'd255;
      5'd2:  t = 9'd251;
      5'd3:  t = 9'd245;
      5'd4:  t = 9'd237;
      5'd5:  t = 9'd226;
      5'd6:  t = 9'd213;
      5'd7:  t = 9'd198;
      5'd8:  t = 9'd181;
      5'd9:  t = 9'd162;
      5'd10: t = 9'd142;
      5'd11: t = 9'd121;
      5'd12: t = 9'd98;
      5'd13: t = 9'd74;
      5'd14: t = 9'd50;
      5'd15: t = 9'd25;
      default: t = 9'd0;
    endcase
    if (kk == 4'd0) return 10'sd181;
    return neg ? -$signed({1'b0, t}) : $signed({1'b0, t});
  endfunction

  function automatic logic [7:0] sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r, s;
`ifdef IDCT_ROUND_EN
    r = acc + (ACC_W'(1) << (SH - 1));
`else
    r = acc;
`endif
    s = r >>> SH;
    if (s[ACC_W-1]) return 8'd0;
    if (|s[ACC_W-2:8]) return 8'd255;
    return s[7:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    coef_d     = coef_q;
    samp_d     = samp_q;
    acc_a_d    = acc_a_q;
    acc_b_d    = acc_b_q;
    cnt_d      = cnt_q;
    oidx_d     = oidx_q;
    in_ready_d = in_ready_q;
    out_en_d   = 1'b0;
    out_a_d    = out_a_q;
    out_b_d    = out_b_q;
    overrun_d  = bus.in_valid & ~in_ready_q;
    p     = cnt_q[6:4];
    k     = cnt_q[3:0];
    cos_c = cos_rom(p, k);
    prod  = ACC_W'(coef_q[k]) * ACC_W'(cos_c);
    sum_a = acc_a_q + prod;
    // odd k flips sign for the mirrored sample 15-p
    sum_b = k[0] ? acc_b_q - prod : acc_b_q + prod;
    unique case (state_q)
      COLLECT: begin
        if (bus.in_valid) begin
          coef_d[bus.INDEX_A] = bus.COEFF_A;
          coef_d[bus.INDEX_B] = bus.COEFF_B;
          mask_d = mask_q
                 | (16'd1 << bus.INDEX_A)
                 | (16'd1 << bus.INDEX_B);
          if (&mask_d) begin
            state_d    = COMPUTE;
            in_ready_d = 1'b0;
            cnt_d      = '0;
          end
        end
      end
      COMPUTE: begin
        cnt_d = cnt_q + 7'd1;
        if (k == 4'd15) begin
          samp_d[{1'b0, p}]  = sat(sum_a);
          samp_d[~{1'b0, p}] = sat(sum_b);
          acc_a_d = '0;
          acc_b_d = '0;
          if (p == 3'd7) state_d = FINAL;
        end else begin
          acc_a_d = sum_a;
          acc_b_d = sum_b;
        end
      end
      FINAL: begin
        state_d = OUTPUT;
        oidx_d  = '0;
      end
      OUTPUT: begin
        if (oidx_q[3]) begin
          state_d    = COLLECT;
          mask_d     = '0;
          in_ready_d = 1'b1;
        end else begin
          out_en_d = 1'b1;
          out_a_d  = samp_q[{1'b0, oidx_q[2:0]}];
          out_b_d  = samp_q[~{1'b0, oidx_q[2:0]}];
          oidx_d   = oidx_q + 4'd1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= COLLECT;
      mask_q     <= '0;
      coef_q     <= '{default: '0};
      samp_q     <= '{default: '0};
      acc_a_q    <= '0;
      acc_b_q    <= '0;
      cnt_q      <= '0;
      oidx_q     <= '0;
      in_ready_q <= 1'b1;
      out_en_q   <= 1'b0;
      overrun_q  <= 1'b0;
      out_a_q    <= '0;
      out_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      coef_q     <= coef_d;
      samp_q     <= samp_d;
      acc_a_q    <= acc_a_d;
      acc_b_q    <= acc_b_d;
      cnt_q      <= cnt_d;
      oidx_q     <= oidx_d;
      in_ready_q <= in_ready_d;
      out_en_q   <= out_en_d;
      overrun_q  <= overrun_d;
      out_a_q    <= out_a_d;
      out_b_q    <= out_b_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.output_en = out_en_q;
  assign bus.overrun   = overrun_q;
  assign bus.OUTPUT_A  = out_a_q;
  assign bus.OUTPUT_B  = out_b_q;
endmodule

// File: tb/tb_idct16_pair.sv
// tb_idct16_pair: directed frames with an output scoreboard for idct16_pair.
// Expected samples come from hand-derived constants for each frame.
module tb_idct16_pair;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  idct16_pair_if bus();

  idct16_pair dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

`ifdef IDCT_ROUND_EN
  localparam int MIX_LO = 136;
  localparam int RND_LO = 3;
`else
  localparam int MIX_LO = 135;
  localparam int RND_LO = 2;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int out_cnt = 0;
  int first_cyc = 0;
  int acc_cyc = 0;
  int saved_acc;
  logic [15:0] sb[$];
  logic signed [23:0] X[16];
  int E[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (bus.output_en === 1'b1) begin
      if (out_cnt == 0) first_cyc = cyc;
      if (sb.size() == 0) begin
        chk("spurious_out_en", 32'(bus.output_en), 0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("outA_%0d", out_cnt), 32'(bus.OUTPUT_A), 32'(e[15:8]));
        chk($sformatf("outB_%0d", out_cnt), 32'(bus.OUTPUT_B), 32'(e[7:0]));
      end
      out_cnt++;
    end
  end

  task automatic send(input logic [3:0] ia, input logic signed [23:0] a,
                      input logic [3:0] ib, input logic signed [23:0] b);
    bus.in_valid = 1'b1;
    bus.INDEX_A  = ia;
    bus.COEFF_A  = a;
    bus.INDEX_B  = ib;
    bus.COEFF_B  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic clr_x();
    for (int i = 0; i < 16; i++) X[i] = '0;
  endtask

  task automatic fill_e(input int v);
    for (int i = 0; i < 16; i++) E[i] = v;
  endtask

  task automatic push_exp();
    out_cnt = 0;
    for (int i = 0; i < 8; i++)
      sb.push_back({8'(E[i]), 8'(E[15-i])});
  endtask

  task automatic send_x();
    for (int i = 0; i < 8; i++)
      send(4'(2*i), X[2*i], 4'(2*i+1), X[2*i+1]);
  endtask

  task automatic finish_frame(input string tag);
    int t = 0;
    while ((sb.size() != 0 || bus.output_en === 1'b1) && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({tag, "_drain"}, sb.size(), 0);
    sb.delete();
    chk({tag, "_latency"}, first_cyc - acc_cyc, 130);
    chk({tag, "_n_out"}, out_cnt, 8);
    chk({tag, "_ready"}, 32'(bus.in_ready), 1);
    chk({tag, "_holdA"}, 32'(bus.OUTPUT_A), E[7]);
    chk({tag, "_holdB"}, 32'(bus.OUTPUT_B), E[8]);
  endtask

  task automatic frame(input string tag);
    push_exp();
    send_x();
    finish_frame(tag);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.COEFF_A = '0;
    bus.COEFF_B = '0;
    bus.INDEX_A = '0;
    bus.INDEX_B = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_output_en", 32'(bus.output_en), 0);
    chk("rst_out_a", 32'(bus.OUTPUT_A), 0);
    chk("rst_out_b", 32'(bus.OUTPUT_B), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    clr_x(); X[0] = 24'sd524288; fill_e(181); frame("dc");
    clr_x(); X[0] = 24'sd2097152; fill_e(255); frame("sat_hi");
    clr_x(); X[0] = -24'sd524288; fill_e(0); frame("sat_lo");
    clr_x(); fill_e(0); frame("zero");

    clr_x(); X[0] = 24'sd524288; X[8] = 24'sd131072;
    for (int n = 0; n < 16; n++)
      E[n] = (n % 4 == 0 || n % 4 == 3) ? 226 : MIX_LO;
    frame("mixed");

    clr_x(); X[0] = 24'sd8000; fill_e(RND_LO); frame("round");

    // reverse order, X[0] first 0 then 524288; index 1 held back
    fill_e(181);
    push_exp();
    send(15, 0, 14, 0); send(13, 0, 12, 0);
    send(11, 0, 10, 0); send(9, 0, 8, 0);
    send(7, 0, 6, 0);   send(5, 0, 4, 0);
    send(3, 0, 2, 0);   send(0, 0, 0, 0);
    chk("partial_ready", 32'(bus.in_ready), 1);
    repeat (5) @(posedge clk);
    #1;
    chk("partial_idle", 32'(bus.in_ready), 1);
    send(1, 0, 0, 24'sd524288);
    finish_frame("rev_dup");

    fill_e(181);
    push_exp();
    send(5, 24'sd1000000, 5, 0);
    send(0, 24'sd524288, 1, 0);
    send(2, 0, 3, 0);   send(4, 0, 6, 0);
    send(7, 0, 8, 0);   send(9, 0, 10, 0);
    send(11, 0, 12, 0); send(13, 0, 14, 0);
    send(15, 0, 15, 0);
    finish_frame("same_idx");

    clr_x(); X[0] = 24'sd524288; fill_e(181);
    push_exp();
    send_x();
    saved_acc = acc_cyc;
    repeat (3) @(posedge clk);
    #1;
    chk("ovr_idle", 32'(bus.overrun), 0);
    bus.in_valid = 1'b1;
    bus.INDEX_A = 0; bus.COEFF_A = 24'sd2097152;
    bus.INDEX_B = 1; bus.COEFF_B = 24'sd2097152;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("ovr_pulse_%0d", i), 32'(bus.overrun), 1);
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("ovr_end", 32'(bus.overrun), 0);
    acc_cyc = saved_acc;
    finish_frame("overrun");

    clr_x(); X[0] = 24'sd524288;
    out_cnt = 0;
    send_x();
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_rst_ready", 32'(bus.in_ready), 1);
    chk("abort_rst_oen", 32'(bus.output_en), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    chk("abort_no_out", out_cnt, 0);
    chk("abort_ready", 32'(bus.in_ready), 1);
    fill_e(181); frame("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
